// File: rtl/conv_encoder_punct_pkg.sv
// rtl/conv_encoder_punct_pkg.sv - shared rate encodings and K=7 generator constants
package conv_encoder_punct_pkg;

  typedef enum logic [1:0] {
    RATE_1_2 = 2'b00,
    RATE_2_3 = 2'b01,
    RATE_3_4 = 2'b10
  } rate_e;

  // Bit 6 is the tap on the current input, bit 0 the tap on the oldest state bit.
  localparam logic [6:0] G0 = 7'o133;
  localparam logic [6:0] G1 = 7'o171;

  // Reserved code 11 is folded onto rate 1/2.
  function automatic rate_e decode_rate(input logic [1:0] sel);
    case (sel)
      2'b01:   return RATE_2_3;
      2'b10:   return RATE_3_4;
      default: return RATE_1_2;
    endcase
  endfunction

endpackage

// File: rtl/conv_encoder_punct_conv_core.sv
// rtl/conv_encoder_punct_conv_core.sv - K=7 shift register and A/B parity trees with clear-on-start
module conv_encoder_punct_conv_core
  import conv_encoder_punct_pkg::*;
(
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_en,
  input  logic i_clear,
  input  logic i_bit,
  output logic o_a,
  output logic o_b
);

  logic [5:0] r_sr;
  logic [5:0] w_sr_eff;
  logic [6:0] w_win;

  // A start bit sees an all-zero history regardless of what the previous frame left behind.
  assign w_sr_eff = i_clear ? 6'd0 : r_sr;
  assign w_win    = {i_bit, w_sr_eff[0], w_sr_eff[1], w_sr_eff[2],
                     w_sr_eff[3], w_sr_eff[4], w_sr_eff[5]};

  assign o_a = ^(w_win & G0);
  assign o_b = ^(w_win & G1);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sr <= 6'd0;
    end else if (i_en) begin
      r_sr <= {w_sr_eff[4:0], i_bit};
    end
  end

endmodule

// File: rtl/conv_encoder_punct.sv
// rtl/conv_encoder_punct.sv - 802.11a rate 1/2, 2/3, 3/4 punctured convolutional encoder
module conv_encoder_punct
  import conv_encoder_punct_pkg::*;
#(
  parameter int RATE_W = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [RATE_W-1:0] rate,
  input  logic              in_start,
  input  logic              data_in,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              data_out,
  output logic              out_valid,
  input  logic              out_ready
);

  logic [1:0] r_cnt;
  logic [1:0] r_buf;
  logic [1:0] r_phase;
  rate_e      r_rate;

  logic       w_in_xfer;
  logic       w_pop;
  logic       w_a;
  logic       w_b;
  rate_e      w_rate;
  logic [1:0] w_phase;
  logic [1:0] w_phase_nxt;
  logic [1:0] w_push_n;
  logic       w_p0;
  logic       w_p1;
  logic [1:0] w_cnt_mid;
  logic [1:0] w_buf_mid;
  logic [1:0] w_cnt_nxt;
  logic [1:0] w_buf_nxt;

  // Only admit a bit when its (up to two) kept outputs are guaranteed to fit.
  assign in_ready  = (r_cnt == 2'd0) || ((r_cnt == 2'd1) && out_ready);
  assign out_valid = (r_cnt != 2'd0);
  assign data_out  = r_buf[0];
  assign w_in_xfer = in_valid && in_ready;
  assign w_pop     = out_valid && out_ready;

  conv_encoder_punct_conv_core u_core (
    .i_clk   (clk),
    .i_rst_n (reset),
    .i_en    (w_in_xfer),
    .i_clear (in_start),
    .i_bit   (data_in),
    .o_a     (w_a),
    .o_b     (w_b)
  );

  always_comb begin
    w_rate      = in_start ? decode_rate(rate[1:0]) : r_rate;
    w_phase     = in_start ? 2'd0 : r_phase;
    w_phase_nxt = 2'd0;
    w_push_n    = 2'd2;
    w_p0        = w_a;
    w_p1        = w_b;
    case (w_rate)
      RATE_2_3: begin
        if (w_phase == 2'd1) begin
          w_push_n = 2'd1;
        end else begin
          w_phase_nxt = 2'd1;
        end
      end
      RATE_3_4: begin
        case (w_phase)
          2'd0: w_phase_nxt = 2'd1;
          2'd1: begin
            w_push_n    = 2'd1;
            w_phase_nxt = 2'd2;
          end
          default: begin
            w_push_n = 2'd1;
            w_p0     = w_b;
          end
        endcase
      end
      default: ;
    endcase
  end

  // Pop first, then append kept bits behind whatever survives.
  always_comb begin
    w_cnt_mid = r_cnt - {1'b0, w_pop};
    w_buf_mid = w_pop ? {1'b0, r_buf[1]} : r_buf;
    w_cnt_nxt = w_cnt_mid;
    w_buf_nxt = w_buf_mid;
    if (w_in_xfer) begin
      w_cnt_nxt = w_cnt_mid + w_push_n;
      if (w_cnt_mid == 2'd0) begin
        w_buf_nxt = {w_p1, w_p0};
      end else begin
        w_buf_nxt[1] = w_p0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt   <= 2'd0;
      r_buf   <= 2'd0;
      r_phase <= 2'd0;
      r_rate  <= RATE_1_2;
    end else begin
      r_cnt <= w_cnt_nxt;
      r_buf <= w_buf_nxt;
      if (w_in_xfer) begin
        r_phase <= w_phase_nxt;
        r_rate  <= w_rate;
      end
    end
  end

endmodule

// File: tb/tb_conv_encoder_punct.sv
// tb/tb_conv_encoder_punct.sv - randomized self-checking bench for conv_encoder_punct
module tb_conv_encoder_punct;

  logic       clk;
  logic       reset;
  logic [1:0] rate;
  logic       in_start;
  logic       data_in;
  logic       in_valid;
  logic       in_ready;
  logic       data_out;
  logic       out_valid;
  logic       out_ready;

  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;
  int pop_cnt = 0;
  int first_pop_cyc = 0;
  int last_pop_cyc  = 0;
  int ready_prob    = 100;
  bit exp_q[$];
  bit prev_hold = 0;
  bit prev_data = 0;

  conv_encoder_punct #(.RATE_W(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .rate      (rate),
    .in_start  (in_start),
    .data_in   (data_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data_out  (data_out),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    out_ready = ($urandom_range(99) < ready_prob);
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Output monitor: every accepted coded bit is compared against the expectation queue.
  always @(negedge clk) begin
    if (!reset) begin
      prev_hold = 0;
    end else begin
      if (prev_hold) begin
        chk("hold_valid", int'(out_valid), 1);
        chk("hold_data", int'(data_out), int'(prev_data));
      end
      prev_hold = out_valid && !out_ready;
      prev_data = data_out;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("extra_bit", 1, 0);
        end else begin
          chk("coded_bit", int'(data_out), int'(exp_q.pop_front()));
        end
        if (pop_cnt == 0) first_pop_cyc = cyc;
        last_pop_cyc = cyc;
        pop_cnt++;
      end
    end
  end

  task automatic push_str(input string s);
    for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i] == "1");
  endtask

  // Reference: parity of generator taps over the frame history, then a keep-mask per rate.
  task automatic model_frame(input int r, input bit bits[$]);
    bit [6:0] g0 = 7'o133;
    bit [6:0] g1 = 7'o171;
    string pat;
    int per;
    bit a, b;
    case (r)
      1:       pat = "1110";
      2:       pat = "111001";
      default: pat = "11";
    endcase
    per = pat.len() / 2;
    for (int i = 0; i < bits.size(); i++) begin
      a = 0;
      b = 0;
      for (int k = 0; k < 7; k++) begin
        if (i - k >= 0) begin
          a ^= bits[i-k] & g0[6-k];
          b ^= bits[i-k] & g1[6-k];
        end
      end
      if (pat[(i % per) * 2] == "1") exp_q.push_back(a);
      if (pat[(i % per) * 2 + 1] == "1") exp_q.push_back(b);
    end
  endtask

  // Entered and left at posedge+1.
  task automatic send(input bit b, input bit st, input logic [1:0] r, input int vprob);
    int guard = 0;
    bit acc = 0;
    while (($urandom_range(99) >= vprob) && guard < 50) begin
      in_valid = 0;
      in_start = 0;
      @(posedge clk);
      #1;
      guard++;
    end
    in_valid = 1;
    in_start = st;
    data_in  = b;
    rate     = st ? r : 2'($urandom_range(3));
    guard    = 0;
    while (!acc && guard < 1000) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      guard++;
    end
    if (!acc) chk("accept_timeout", 0, 1);
    in_valid = 0;
    in_start = 0;
  endtask

  task automatic send_impulse(input logic [1:0] r, input int zeros, input int vprob);
    send(1'b1, 1'b1, r, vprob);
    for (int i = 0; i < zeros; i++) send(1'b0, 1'b0, r, vprob);
  endtask

  task automatic drain();
    int guard = 0;
    while (exp_q.size() != 0 && guard < 3000) begin
      @(posedge clk);
      #1;
      guard++;
    end
    chk("drain_left", exp_q.size(), 0);
    ready_prob = 100;
    repeat (3) @(posedge clk);
    #1;
    chk("idle_valid", int'(out_valid), 0);
    chk("idle_ready", int'(in_ready), 1);
  endtask

  initial begin
    bit bits[$];
    int r;
    int len;
    int vprob;
    reset    = 0;
    rate     = 0;
    in_start = 0;
    data_in  = 0;
    in_valid = 0;
    out_ready = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_ready", int'(in_ready), 1);
    chk("rst_data", int'(data_out), 0);
    #2 reset = 1;
    @(posedge clk);
    #1;

    // all-zero frame at full throughput
    for (int i = 0; i < 32; i++) exp_q.push_back(1'b0);
    pop_cnt = 0;
    send(1'b0, 1'b1, 2'd0, 100);
    for (int i = 0; i < 15; i++) send(1'b0, 1'b0, 2'd0, 100);
    drain();
    chk("zero_count", pop_cnt, 32);
    chk("zero_span", last_pop_cyc - first_pop_cyc, 31);

    push_str("11011111001011");
    send_impulse(2'd0, 6, 100);
    drain();

    push_str("110111001110");
    send_impulse(2'd1, 7, 100);
    drain();

    push_str("110111001100");
    send_impulse(2'd2, 8, 100);
    drain();

    push_str("11011111001011");
    send_impulse(2'd3, 6, 100);
    drain();

    // backpressure, back-to-back impulse frames
    ready_prob = 40;
    pop_cnt = 0;
    for (int f = 0; f < 3; f++) begin
      push_str("11011111001011");
      send_impulse(2'd0, 6, 50);
    end
    drain();
    chk("bp_count", pop_cnt, 42);

    // random frames, each new start cutting the previous one short
    for (int f = 0; f < 10; f++) begin
      r = $urandom_range(3);
      len = $urandom_range(30, 1);
      vprob = $urandom_range(100, 30);
      ready_prob = $urandom_range(100, 30);
      bits.delete();
      for (int i = 0; i < len; i++) bits.push_back(1'($urandom_range(1)));
      model_frame(r, bits);
      for (int i = 0; i < len; i++) send(bits[i], i == 0, 2'(r), vprob);
    end
    drain();

    // reset with buffered bits, then restart at 3/4
    ready_prob = 0;
    out_ready = 0;
    send(1'b1, 1'b1, 2'd0, 100);
    chk("pre_rst_valid", int'(out_valid), 1);
    #2 reset = 0;
    #1;
    chk("mid_rst_valid", int'(out_valid), 0);
    chk("mid_rst_ready", int'(in_ready), 1);
    chk("mid_rst_data", int'(data_out), 0);
    exp_q.delete();
    @(posedge clk);
    #3 reset = 1;
    ready_prob = 100;
    @(posedge clk);
    #1;
    push_str("110111001100");
    send_impulse(2'd2, 8, 100);
    drain();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
